// File: rtl/memmapper_if.sv
// Bus bundle for the memory mapper: register port, live CPU access signals
// and the mapper's outputs toward the external-bus logic.
interface memmapper_if #(
  parameter int EXT_AW = 17
);
  logic [4:0]        AD;
  logic [7:0]        DI;
  logic [7:0]        DO;
  logic              rw;
  logic              cs;
  logic [15:0]       cpu_addr;
  logic              cpu_vma;
  logic              cpu_rw;
  logic              ext_sel;
  logic [EXT_AW-1:0] ext_addr;
  logic              win_hit;
  logic              wr_block;
  logic              hold;
  logic              irq;
  logic              bram_disable;

  modport slave (
    input  AD, DI, rw, cs, cpu_addr, cpu_vma, cpu_rw, ext_sel,
    output DO, ext_addr, win_hit, wr_block, hold, irq, bram_disable
  );

  modport master (
    output AD, DI, rw, cs, cpu_addr, cpu_vma, cpu_rw, ext_sel,
    input  DO, ext_addr, win_hit, wr_block, hold, irq, bram_disable
  );
endinterface

// File: rtl/memmapper.sv
// Multi-window CPU-to-SRAM page mapper with per-window enable/write-protect,
// a sticky write-violation flag with interrupt, and an external-bus
// wait-state generator driving CPU hold.
module memmapper #(
  parameter int NWIN      = 4,
  parameter int WIN_BITS  = 13,
  parameter int PAGE_BITS = 3,
  parameter int WAIT_W    = 3,
  parameter int WAIT_RST  = 0
) (
  input logic        clk,
  input logic        rst,
  memmapper_if.slave bus
);
  localparam int EXT_AW = 1 + PAGE_BITS + WIN_BITS;
  localparam int BASE_W = 16 - WIN_BITS;
  localparam int SEL_W  = (NWIN > 1) ? $clog2(NWIN) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, WAITING = 1'b1} state_t;

  logic [PAGE_BITS-1:0] page [NWIN];
  logic [BASE_W-1:0]    base [NWIN];
  logic [NWIN-1:0]      en;
  logic [NWIN-1:0]      wp;
  logic [WAIT_W-1:0]    wait_states;
  logic                 bram_dis;
  logic                 viol;
  logic                 irqen;
  state_t               state;
  logic [WAIT_W-1:0]    cnt;

  logic                 hit;
  logic [SEL_W-1:0]     sel;
  logic                 wr_blk;
  logic                 reg_wr;
  logic                 stat_wr;
  logic                 ext_req;
  logic [7:0]           rd_data;
  logic                 unused_di;

  assign reg_wr    = bus.cs && !bus.rw;
  assign stat_wr   = reg_wr && (bus.AD == 5'h19);
  assign ext_req   = bus.ext_sel && bus.cpu_vma && !bus.cs;
  assign unused_di = ^bus.DI;

  // Window match: scan from the top so the lowest matching index wins.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = NWIN - 1; i >= 0; i--) begin
      if (en[i] && (bus.cpu_addr[15:WIN_BITS] == base[i])) begin
        hit = 1'b1;
        sel = SEL_W'(i);
      end else begin
        hit = hit;
      end
    end
  end

  // Address translation and write-protect detection.
  always_comb begin
    if (hit) begin
      bus.ext_addr = {1'b1, page[sel], bus.cpu_addr[WIN_BITS-1:0]};
      wr_blk       = wp[sel] && !bus.cpu_rw && bus.cpu_vma;
    end else begin
      bus.ext_addr = {{(EXT_AW-16){1'b0}}, bus.cpu_addr};
      wr_blk       = 1'b0;
    end
  end

  assign bus.win_hit      = hit;
  assign bus.wr_block     = wr_blk;
  assign bus.irq          = viol && irqen;
  assign bus.bram_disable = bram_dis;
  assign bus.DO           = rd_data;

  // Register read mux; holes in the map read all-ones.
  always_comb begin
    rd_data = 8'hFF;
    case (bus.AD[4:3])
      2'b00: begin
        for (int i = 0; i < NWIN; i++) begin
          if (bus.AD[2:0] == 3'(i)) rd_data = 8'(page[i]);
          else rd_data = rd_data;
        end
      end
      2'b01: begin
        for (int i = 0; i < NWIN; i++) begin
          if (bus.AD[2:0] == 3'(i)) rd_data = {6'b000000, wp[i], en[i]};
          else rd_data = rd_data;
        end
      end
      2'b10: begin
        for (int i = 0; i < NWIN; i++) begin
          if (bus.AD[2:0] == 3'(i)) rd_data = 8'(base[i]);
          else rd_data = rd_data;
        end
      end
      2'b11: begin
        if (bus.AD[2:0] == 3'd0) begin
          rd_data              = 8'h00;
          rd_data[WAIT_W-1:0]  = wait_states;
          rd_data[7]           = bram_dis;
        end else if (bus.AD[2:0] == 3'd1) begin
          rd_data = {6'b000000, irqen, viol};
        end else begin
          rd_data = 8'hFF;
        end
      end
      default: rd_data = 8'hFF;
    endcase
  end

  // Configuration registers: page, control, base and wait/BRAM settings.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NWIN; i++) begin
        page[i] <= '0;
        base[i] <= '0;
      end
      en          <= '0;
      wp          <= '0;
      wait_states <= WAIT_W'(WAIT_RST);
      bram_dis    <= 1'b0;
    end else if (reg_wr) begin
      for (int i = 0; i < NWIN; i++) begin
        if (bus.AD == {2'b00, 3'(i)}) page[i] <= bus.DI[PAGE_BITS-1:0];
        if (bus.AD == {2'b01, 3'(i)}) begin
          en[i] <= bus.DI[0];
          wp[i] <= bus.DI[1];
        end
        if (bus.AD == {2'b10, 3'(i)}) base[i] <= bus.DI[BASE_W-1:0];
      end
      if (bus.AD == 5'h18) begin
        wait_states <= bus.DI[WAIT_W-1:0];
        bram_dis    <= bus.DI[7];
      end
    end else begin
      bram_dis <= bram_dis;
    end
  end

  // Status: sticky violation (set beats write-1-clear) and interrupt enable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      viol  <= 1'b0;
      irqen <= 1'b0;
    end else begin
      if (stat_wr) irqen <= bus.DI[1];
      else irqen <= irqen;
      if (wr_blk) viol <= 1'b1;
      else if (stat_wr && bus.DI[0]) viol <= 1'b0;
      else viol <= viol;
    end
  end

  // Wait-state sequencer: the IDLE cycle counts as the first held cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ext_req && (wait_states != '0)) begin
            cnt   <= wait_states - WAIT_W'(1'b1);
            state <= WAITING;
          end else begin
            state <= IDLE;
          end
        end
        WAITING: begin
          if (cnt != '0) cnt <= cnt - WAIT_W'(1'b1);
          else state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Hold is asserted in the request cycle and while the counter is non-zero.
  always_comb begin
    if (state == WAITING) bus.hold = (cnt != '0);
    else bus.hold = ext_req && (wait_states != '0);
  end
endmodule

// File: tb/tb_memmapper.sv
// Scoreboard bench for memmapper: stimulus pushes expected outputs, a
// negedge monitor pops and compares them against the live DUT outputs.
module tb_memmapper;
  localparam int S_DO   = 0;
  localparam int S_EXT  = 1;
  localparam int S_HIT  = 2;
  localparam int S_WRB  = 3;
  localparam int S_HOLD = 4;
  localparam int S_IRQ  = 5;
  localparam int S_BRAM = 6;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  logic clk;
  logic rst;
  memmapper_if #(.EXT_AW(17)) bus ();

  memmapper u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  chk_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] actual(int s);
    case (s)
      S_DO:    return 32'(bus.DO);
      S_EXT:   return 32'(bus.ext_addr);
      S_HIT:   return 32'(bus.win_hit);
      S_WRB:   return 32'(bus.wr_block);
      S_HOLD:  return 32'(bus.hold);
      S_IRQ:   return 32'(bus.irq);
      S_BRAM:  return 32'(bus.bram_disable);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: compare every expectation queued for this cycle.
  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      chk_t c;
      logic [31:0] a;
      c = sbq.pop_front();
      a = actual(c.sel);
      n_chk++;
      if (a !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", c.name, a, c.exp);
      end
    end
  end

  task automatic expect_out(string n, int s, logic [31:0] e);
    sbq.push_back('{n, s, e});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(logic [4:0] a, logic [7:0] d);
    bus.cs = 1'b1; bus.rw = 1'b0; bus.AD = a; bus.DI = d;
    step();
    bus.cs = 1'b0; bus.rw = 1'b1;
  endtask

  task automatic reg_rd(string n, logic [4:0] a, logic [7:0] e);
    bus.cs = 1'b1; bus.rw = 1'b1; bus.AD = a;
    expect_out(n, S_DO, 32'(e));
    step();
    bus.cs = 1'b0;
  endtask

  task automatic cpu(logic [15:0] a, logic vma, logic r);
    bus.cpu_addr = a; bus.cpu_vma = vma; bus.cpu_rw = r;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    bus.AD = 5'h00; bus.DI = 8'h00; bus.rw = 1'b1; bus.cs = 1'b0;
    bus.cpu_addr = 16'h0000; bus.cpu_vma = 1'b0; bus.cpu_rw = 1'b1; bus.ext_sel = 1'b0;
    step();
    step();
    rst = 1'b1;

    // Reset state
    expect_out("rst_hold", S_HOLD, 32'd0);
    expect_out("rst_irq", S_IRQ, 32'd0);
    expect_out("rst_hit", S_HIT, 32'd0);
    expect_out("rst_wrb", S_WRB, 32'd0);
    expect_out("rst_bram", S_BRAM, 32'd0);
    reg_rd("rst_page0", 5'h00, 8'h00);
    reg_rd("rst_ctrl0", 5'h08, 8'h00);
    reg_rd("rst_base0", 5'h10, 8'h00);
    reg_rd("rst_wait", 5'h18, 8'h00);
    reg_rd("rst_stat", 5'h19, 8'h00);
    reg_rd("hole_05", 5'h05, 8'hFF);
    reg_rd("hole_1f", 5'h1F, 8'hFF);

    // Basic mapping through window 0
    reg_wr(5'h00, 8'h05);
    reg_wr(5'h10, 8'h06);
    reg_wr(5'h08, 8'h01);
    reg_rd("page0_rb", 5'h00, 8'h05);
    cpu(16'hC123, 1'b1, 1'b1);
    expect_out("map_hit", S_HIT, 32'd1);
    expect_out("map_ext", S_EXT, 32'h1A123);
    expect_out("map_wrb", S_WRB, 32'd0);
    step();
    cpu(16'hA123, 1'b1, 1'b1);
    expect_out("miss_hit", S_HIT, 32'd0);
    expect_out("miss_ext", S_EXT, 32'h0A123);
    step();

    // Priority between overlapping windows
    cpu(16'h0000, 1'b0, 1'b1);
    reg_wr(5'h12, 8'h06);
    reg_wr(5'h02, 8'h03);
    reg_wr(5'h0A, 8'h01);
    reg_rd("base2_rb", 5'h12, 8'h06);
    cpu(16'hC123, 1'b1, 1'b1);
    expect_out("prio_ext", S_EXT, 32'h1A123);
    step();
    cpu(16'h0000, 1'b0, 1'b1);
    reg_wr(5'h08, 8'h00);
    cpu(16'hC123, 1'b1, 1'b1);
    expect_out("prio2_hit", S_HIT, 32'd1);
    expect_out("prio2_ext", S_EXT, 32'h16123);
    step();

    // Write protect, violation and interrupt
    cpu(16'h0000, 1'b0, 1'b1);
    reg_wr(5'h0A, 8'h00);
    reg_wr(5'h08, 8'h03);
    reg_wr(5'h19, 8'h02);
    cpu(16'hC000, 1'b1, 1'b1);
    expect_out("wp_read_wrb", S_WRB, 32'd0);
    step();
    cpu(16'hC000, 1'b1, 1'b0);
    expect_out("wp_wrb", S_WRB, 32'd1);
    expect_out("wp_ext", S_EXT, 32'h1A000);
    expect_out("wp_irq_pre", S_IRQ, 32'd0);
    step();
    cpu(16'h0000, 1'b0, 1'b1);
    expect_out("wp_irq", S_IRQ, 32'd1);
    reg_rd("wp_stat", 5'h19, 8'h03);
    reg_wr(5'h19, 8'h03);
    expect_out("clr_irq", S_IRQ, 32'd0);
    reg_rd("clr_stat", 5'h19, 8'h02);
    cpu(16'hC000, 1'b1, 1'b0);
    reg_wr(5'h19, 8'h03);
    cpu(16'h0000, 1'b0, 1'b1);
    expect_out("setwins_irq", S_IRQ, 32'd1);
    reg_rd("setwins_stat", 5'h19, 8'h03);
    reg_wr(5'h19, 8'h01);
    reg_rd("irqen_off", 5'h19, 8'h00);

    // Wait states
    reg_wr(5'h18, 8'h83);
    expect_out("bram_dis", S_BRAM, 32'd1);
    reg_rd("wait_rb", 5'h18, 8'h83);
    cpu(16'h8000, 1'b1, 1'b1);
    bus.ext_sel = 1'b1;
    for (int k = 0; k < 4; k++) begin
      expect_out($sformatf("w3_hold%0d", k), S_HOLD, (k < 3) ? 32'd1 : 32'd0);
      step();
    end
    bus.ext_sel = 1'b0;
    expect_out("w3_idle", S_HOLD, 32'd0);
    step();
    reg_wr(5'h18, 8'h00);
    bus.ext_sel = 1'b1;
    for (int k = 0; k < 2; k++) begin
      expect_out($sformatf("w0_hold%0d", k), S_HOLD, 32'd0);
      step();
    end
    bus.ext_sel = 1'b0;

    // Reset in the middle of a wait sequence
    reg_wr(5'h18, 8'h05);
    bus.ext_sel = 1'b1;
    expect_out("w5_hold0", S_HOLD, 32'd1);
    step();
    rst = 1'b0;
    expect_out("w5_hold1", S_HOLD, 32'd1);
    step();
    expect_out("w5_after_rst", S_HOLD, 32'd0);
    step();
    rst = 1'b1;
    bus.ext_sel = 1'b0;
    reg_rd("mid_rst_wait", 5'h18, 8'h00);
    reg_rd("mid_rst_ctrl0", 5'h08, 8'h00);
    reg_rd("mid_rst_stat", 5'h19, 8'h00);
    reg_wr(5'h18, 8'h02);
    bus.ext_sel = 1'b1;
    for (int k = 0; k < 3; k++) begin
      expect_out($sformatf("w2_hold%0d", k), S_HOLD, (k < 2) ? 32'd1 : 32'd0);
      step();
    end
    bus.ext_sel = 1'b0;

    repeat (3) step();
    if (sbq.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
